data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the array; power of two, at least 4.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each response; range 0 to 15.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 Port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 Port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 Port req_addr, input, 32 bits: byte address.
REQ-009 Port req_wdata, input, 32 bits: write data.
REQ-010 Port resp_valid, output, 1 bit: a response is presented.
REQ-011 Port resp_ready, input, 1 bit: the initiator consumes the response.
REQ-012 Port resp_rdata, output, 32 bits: read data; 0 for writes.
REQ-013 Port resp_err, output, 1 bit: error response (see Configuration).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP; one transaction outstanding at most.
REQ-015 req_ready SHALL be 1 in IDLE only; a request is accepted on a rising edge when req_valid and req_ready are both 1.
REQ-016 On acceptance, req_we, req_addr and req_wdata SHALL be captured; the state SHALL go to WAIT if WAIT_CYCLES > 0, otherwise to RESP.
REQ-017 In WAIT, a 4-bit counter SHALL be loaded with WAIT_CYCLES-1 on entry and decremented each cycle; the state SHALL go to RESP on the edge where the counter reads 0.
REQ-018 On the edge entering RESP: a write SHALL update array[addr[log2(DEPTH)+1:2]]; a read SHALL register that word into resp_rdata.
REQ-019 resp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be stable until the edge where resp_ready is 1; the state then SHALL return to IDLE.
REQ-021 A req_valid asserted while in RESP SHALL NOT be accepted, even if resp_ready is 1 in the same cycle; it is accepted no earlier than the next IDLE cycle.
REQ-022 addr[1:0] SHALL be ignored, and upper address bits SHALL wrap modulo DEPTH, unless DMEM_ERR_EN is defined.
REQ-023 A read following a write to the same word SHALL return the newly written data.
REQ-024 resp_valid SHALL be 0 outside RESP; resp_rdata SHALL hold its last value outside RESP.

Reset
REQ-025 While reset is 0: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, captured registers=0, req_ready=1 once reset is released.
REQ-026 Array contents SHALL NOT be cleared by reset.
REQ-027 Reset asserted in WAIT SHALL abandon the transaction with no array write.

Configuration
REQ-028 Macro DMEM_ERR_EN defined: a request with addr[1:0] != 0 or addr >= DEPTH*4 SHALL get resp_err=1 and resp_rdata=0, with no array write and unchanged latency.
REQ-029 Macro DMEM_ERR_EN undefined: resp_err SHALL be tied 0 and addressing SHALL follow REQ-022.

Structure
REQ-030 Package tessia_mem_pkg SHALL hold the dmem_state_t enum (IDLE, WAIT, RESP), WORD_W=32 and MAX_WAIT=15.
REQ-031 Storage SHALL be the sub-module dmem_array: DEPTH x 32 bits, synchronous write, combinational read, instantiated once.

Verification
REQ-032 After reset, write 0xDEADBEEF to 0x10, then read 0x10 -> resp_rdata=0xDEADBEEF and resp_err=0; resp_valid rises 3 cycles after each accept edge (WAIT_CYCLES=2).
REQ-033 WAIT_CYCLES=0: read 0x0 -> resp_valid on the first edge after accept; hold resp_ready=0 for 4 cycles -> resp_valid and resp_rdata stable; req_ready=0 throughout.
REQ-034 DEPTH=64, macro undefined: write 0x11 to 0x100, read 0x0 -> 0x11 (wrap); same sequence with the macro defined -> the write gets resp_err=1, memory at 0x0 unchanged.
REQ-035 Macro defined: read 0x6 -> resp_err=1, resp_rdata=0.
REQ-036 Write 0x5A5A5A5A to 0x20; assert reset in the second WAIT cycle; release; read 0x20 -> previous value returned, no response for the aborted write.

Source files
------------

// File: rtl/tessia_mem_pkg.sv
// Shared types and constants for the data memory responder.
package tessia_mem_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned MAX_WAIT = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD_W storage: synchronous write, combinational read, no reset.
module dmem_array
   import tessia_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wrEn,
   input  logic [AW-1:0]     wrAddr,
   input  logic [WORD_W-1:0] wrData,
   input  logic [AW-1:0]     rdAddr,
   output logic [WORD_W-1:0] rdData
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[wrAddr] <= wrData;
      end
   end

   assign rdData = mem[rdAddr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with configurable wait states.
// Define DMEM_ERR_EN to flag misaligned or out-of-range addresses with resp_err.
module data_mem_responder
   import tessia_mem_pkg::*;
#(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
   localparam logic [3:0]  WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

   dmem_state_t       state;
   logic [3:0]        waitCnt;
   logic              capWe;
   logic [31:0]       capAddr;
   logic [WORD_W-1:0] capWdata;
   logic [WORD_W-1:0] rdataReg;
   logic              errReg;

   logic              accept;
   logic              enterResp;
   logic              opWe;
   logic [31:0]       opAddr;
   logic [WORD_W-1:0] opWdata;
   logic              opErr;
   logic              arrWe;
   logic [WORD_W-1:0] arrRdata;

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_rdata = rdataReg;
   assign resp_err   = errReg;

   assign accept = req_valid && (state == IDLE);

   // With no wait states the access happens on the accept edge itself, so the
   // operation comes straight from the request pins rather than the capture regs.
   assign enterResp = (NO_WAIT && accept) || ((state == WAIT) && (waitCnt == 4'd0));
   assign opWe      = (state == IDLE) ? req_we    : capWe;
   assign opAddr    = (state == IDLE) ? req_addr  : capAddr;
   assign opWdata   = (state == IDLE) ? req_wdata : capWdata;

`ifdef DMEM_ERR_EN
   assign opErr = (opAddr[1:0] != 2'b00) || (opAddr[31:AW+2] != '0);
`else
   logic unusedAddrBits;
   assign unusedAddrBits = ^{opAddr[31:AW+2], opAddr[1:0]};
   assign opErr          = 1'b0;
`endif

   assign arrWe = enterResp && opWe && !opErr;

   dmem_array #(
      .DEPTH (DEPTH)
   ) uArray (
      .clk    (clk),
      .wrEn   (arrWe),
      .wrAddr (opAddr[AW+1:2]),
      .wrData (opWdata),
      .rdAddr (opAddr[AW+1:2]),
      .rdData (arrRdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         waitCnt  <= 4'd0;
         capWe    <= 1'b0;
         capAddr  <= '0;
         capWdata <= '0;
         rdataReg <= '0;
         errReg   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  capWe    <= req_we;
                  capAddr  <= req_addr;
                  capWdata <= req_wdata;
                  waitCnt  <= WAIT_INIT;
                  state    <= NO_WAIT ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (waitCnt == 4'd0) begin
                  state <= RESP;
               end else begin
                  waitCnt <= waitCnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (enterResp) begin
            errReg   <= opErr;
            rdataReg <= (opWe || opErr) ? '0 : arrRdata;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance 0 has WAIT_CYCLES=2, instance 1 has WAIT_CYCLES=0.
module tb_data_mem_responder;

   logic        clk;
   logic        reset;
   logic        reqValid  [2];
   logic        reqReady  [2];
   logic        reqWe     [2];
   logic [31:0] reqAddr   [2];
   logic [31:0] reqWdata  [2];
   logic        respValid [2];
   logic        respReady [2];
   logic [31:0] respRdata [2];
   logic        respErr   [2];

   int nVec = 0;
   int nMis = 0;

`ifdef DMEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dutSlow (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (reqValid[0]),
      .req_ready  (reqReady[0]),
      .req_we     (reqWe[0]),
      .req_addr   (reqAddr[0]),
      .req_wdata  (reqWdata[0]),
      .resp_valid (respValid[0]),
      .resp_ready (respReady[0]),
      .resp_rdata (respRdata[0]),
      .resp_err   (respErr[0])
   );

   data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dutFast (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (reqValid[1]),
      .req_ready  (reqReady[1]),
      .req_we     (reqWe[1]),
      .req_addr   (reqAddr[1]),
      .req_wdata  (reqWdata[1]),
      .resp_valid (respValid[1]),
      .resp_ready (respReady[1]),
      .resp_rdata (respRdata[1]),
      .resp_err   (respErr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp)
      else begin
         nMis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction; lat is the index of the first edge after the accept
   // edge at which resp_valid is sampled high (0 if it never appears).
   task automatic txn(input int s, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd,
                      output logic er, output int lat);
      lat = 0;
      @(negedge clk);
      reqValid[s] = 1'b1;
      reqWe[s]    = we;
      reqAddr[s]  = addr;
      reqWdata[s] = wdata;
      @(posedge clk);
      #1 reqValid[s] = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (respValid[s] === 1'b1) begin
            lat = k;
            break;
         end
      end
      rd = respRdata[s];
      er = respErr[s];
      respReady[s] = 1'b1;
      @(posedge clk);
      #1 respReady[s] = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   logic        sawValid;

   initial begin
      for (int i = 0; i < 2; i++) begin
         reqValid[i]  = 1'b0;
         reqWe[i]     = 1'b0;
         reqAddr[i]   = '0;
         reqWdata[i]  = '0;
         respReady[i] = 1'b0;
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready",  {31'd0, reqReady[0]},  32'd1);
      check("rst_resp_valid", {31'd0, respValid[0]}, 32'd0);
      check("rst_resp_rdata", respRdata[0],          32'd0);
      check("rst_resp_err",   {31'd0, respErr[0]},   32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", {31'd0, reqReady[1]}, 32'd1);

      // Basic write then read-back, two wait states.
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
      check("wr10_lat",   lat, 32'd3);
      check("wr10_err",   {31'd0, er}, 32'd0);
      check("wr10_rdata", rd, 32'd0);
      txn(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
      check("rd10_lat",   lat, 32'd3);
      check("rd10_rdata", rd, 32'hDEADBEEF);
      check("rd10_err",   {31'd0, er}, 32'd0);

      // Zero wait states, response held off for four cycles.
      txn(1, 1'b1, 32'h0, 32'hCAFEF00D, rd, er, lat);
      check("fast_wr_lat", lat, 32'd1);
      @(negedge clk);
      reqValid[1] = 1'b1;
      reqWe[1]    = 1'b0;
      reqAddr[1]  = 32'h0;
      @(posedge clk);
      #1;
      check("fast_rd_rise", {31'd0, respValid[1]}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("hold_valid", {31'd0, respValid[1]}, 32'd1);
         check("hold_rdata", respRdata[1], 32'hCAFEF00D);
         check("hold_ready", {31'd0, reqReady[1]}, 32'd0);
      end
      // Consume while a new request is pending: it must not be taken from RESP.
      respReady[1] = 1'b1;
      @(posedge clk);
      #1 respReady[1] = 1'b0;
      @(negedge clk);
      check("no_accept_valid", {31'd0, respValid[1]}, 32'd0);
      check("no_accept_ready", {31'd0, reqReady[1]}, 32'd1);
      reqValid[1] = 1'b0;

      // Address wrap versus error reporting.
      txn(0, 1'b1, 32'h0, 32'h12345678, rd, er, lat);
      txn(0, 1'b1, 32'h100, 32'h11, rd, er, lat);
      check("wr100_err", {31'd0, er}, {31'd0, ERR_EN});
      check("wr100_lat", lat, 32'd3);
      txn(0, 1'b0, 32'h0, 32'h0, rd, er, lat);
      check("rd0_after_wrap", rd, ERR_EN ? 32'h12345678 : 32'h11);

      txn(0, 1'b1, 32'h4, 32'h0BADF00D, rd, er, lat);
      txn(0, 1'b0, 32'h6, 32'h0, rd, er, lat);
      check("rd6_err",   {31'd0, er}, {31'd0, ERR_EN});
      check("rd6_rdata", rd, ERR_EN ? 32'h0 : 32'h0BADF00D);
      check("rd6_lat",   lat, 32'd3);
      txn(0, 1'b0, 32'h13, 32'h0, rd, er, lat);
      check("rd13_rdata", rd, ERR_EN ? 32'h0 : 32'hDEADBEEF);

      // Reset during the second wait cycle abandons the write.
      txn(0, 1'b1, 32'h20, 32'h77770020, rd, er, lat);
      txn(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
      @(negedge clk);
      reqValid[0] = 1'b1;
      reqWe[0]    = 1'b1;
      reqAddr[0]  = 32'h20;
      reqWdata[0] = 32'h5A5A5A5A;
      @(posedge clk);
      #1 reqValid[0] = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("abort_valid", {31'd0, respValid[0]}, 32'd0);
      check("abort_ready", {31'd0, reqReady[0]},  32'd1);
      check("abort_rdata", respRdata[0],          32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      sawValid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (respValid[0] !== 1'b0) sawValid = 1'b1;
      end
      check("abort_no_resp", {31'd0, sawValid}, 32'd0);
      txn(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
      check("rd20_after_abort", rd, 32'h77770020);
      check("rd20_lat", lat, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
